// File: rtl/lenet_pkg.sv
// Shared constants, FSM encoding and sizing helper for the LeNet feature-map sequencers.
package lenet_pkg;
  localparam int IMG_W_DEF = 28;
  localparam int IMG_H_DEF = 28;
  localparam int K_DEF     = 5;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

  function automatic int addr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/window_addr_gen.sv
// Raster walk over every KxK stride-1 window; address built from window base + row offset + kx.
module window_addr_gen
  import lenet_pkg::*;
#(
  parameter int IMG_W  = IMG_W_DEF,
  parameter int IMG_H  = IMG_H_DEF,
  parameter int K      = K_DEF,
  parameter int ADDR_W = addr_width(IMG_W * IMG_H)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              advance,
  output logic [ADDR_W-1:0] addr,
  output logic              last_tap,
  output logic              last_win
);
  localparam int OUT_W = IMG_W - K + 1;
  localparam int OUT_H = IMG_H - K + 1;
  localparam logic [ADDR_W-1:0] K_M1     = ADDR_W'(K - 1);
  localparam logic [ADDR_W-1:0] OW_M1    = ADDR_W'(OUT_W - 1);
  localparam logic [ADDR_W-1:0] OH_M1    = ADDR_W'(OUT_H - 1);
  localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
  localparam logic [ADDR_W-1:0] ONE      = ADDR_W'(1);
  // Base sits at oy*IMG_W + IMG_W-K when ox wraps, so +K lands on the next row start.
  localparam logic [ADDR_W-1:0] WRAP_STEP = ADDR_W'(K);

  logic [ADDR_W-1:0] kx_q, kx_d, ky_q, ky_d, ox_q, ox_d, oy_q, oy_d;
  logic [ADDR_W-1:0] base_q, base_d, row_q, row_d;

  always_comb begin
    kx_d   = kx_q;
    ky_d   = ky_q;
    ox_d   = ox_q;
    oy_d   = oy_q;
    base_d = base_q;
    row_d  = row_q;
    if (clear) begin
      kx_d   = '0;
      ky_d   = '0;
      ox_d   = '0;
      oy_d   = '0;
      base_d = '0;
      row_d  = '0;
    end else if (advance) begin
      if (kx_q != K_M1) begin
        kx_d = kx_q + ONE;
      end else begin
        kx_d = '0;
        if (ky_q != K_M1) begin
          ky_d  = ky_q + ONE;
          row_d = row_q + ROW_STEP;
        end else begin
          ky_d  = '0;
          row_d = '0;
          if (ox_q != OW_M1) begin
            ox_d   = ox_q + ONE;
            base_d = base_q + ONE;
          end else begin
            ox_d = '0;
            if (oy_q != OH_M1) begin
              oy_d   = oy_q + ONE;
              base_d = base_q + WRAP_STEP;
            end else begin
              oy_d   = '0;
              base_d = '0;
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      kx_q   <= '0;
      ky_q   <= '0;
      ox_q   <= '0;
      oy_q   <= '0;
      base_q <= '0;
      row_q  <= '0;
    end else begin
      kx_q   <= kx_d;
      ky_q   <= ky_d;
      ox_q   <= ox_d;
      oy_q   <= oy_d;
      base_q <= base_d;
      row_q  <= row_d;
    end
  end

  assign addr     = base_q + row_q + kx_q;
  assign last_tap = (kx_q == K_M1) && (ky_q == K_M1);
  assign last_win = last_tap && (ox_q == OW_M1) && (oy_q == OH_M1);
endmodule

// File: rtl/conv_window_reader.sv
// Streams all KxK windows of a stored image from a 1-cycle-latency memory onto a valid/ready port.
module conv_window_reader
  import lenet_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int IMG_W      = IMG_W_DEF,
  parameter int IMG_H      = IMG_H_DEF,
  parameter int K          = K_DEF,
  parameter int MEM_SIZE   = IMG_W * IMG_H,
  localparam int ADDR_W    = addr_width(MEM_SIZE)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  mem_rd_en,
  output logic                  mem_wr_en,
  output logic [ADDR_W-1:0]     mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  out_last_tap,
  output logic                  out_last_win
);
  state_e state_q, state_d;
  logic   out_valid_q, out_valid_d;
  logic   last_tap_q, last_tap_d, last_win_q, last_win_d;
  logic   gen_last_tap, gen_last_win, start_ok;

  // A read is only launched when the beat it replaces is gone, so the memory
  // output register doubles as the output stage.
  assign mem_rd_en = (state_q == RUN) && (!out_valid_q || out_ready);
  assign start_ok  = (state_q == IDLE) && start;

  window_addr_gen #(
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .K     (K),
    .ADDR_W(ADDR_W)
  ) u_addr_gen (
    .clk     (clk),
    .rst     (rst),
    .clear   (start_ok),
    .advance (mem_rd_en),
    .addr    (mem_addr),
    .last_tap(gen_last_tap),
    .last_win(gen_last_win)
  );

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    last_tap_d  = last_tap_q;
    last_win_d  = last_win_q;
    case (state_q)
      IDLE:    if (start) state_d = RUN;
      RUN:     if (mem_rd_en && gen_last_win) state_d = DRAIN;
      DRAIN:   if (out_valid_q && out_ready) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (mem_rd_en) begin
      out_valid_d = 1'b1;
      last_tap_d  = gen_last_tap;
      last_win_d  = gen_last_win;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      last_tap_q  <= 1'b0;
      last_win_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      last_tap_q  <= last_tap_d;
      last_win_q  <= last_win_d;
    end
  end

  assign busy         = (state_q == RUN) || (state_q == DRAIN);
  assign done         = (state_q == DONE);
  assign mem_wr_en    = 1'b0;
  assign out_data     = mem_rdata;
  assign out_valid    = out_valid_q;
  assign out_last_tap = last_tap_q;
  assign out_last_win = last_win_q;
endmodule
